// File: rtl/loopback_selftest_if.sv
// Pad-side bus of the loopback self-test harness: control, pattern out,
// looped-back data in, and run status.
interface loopback_selftest_if #(
   parameter int unsigned WIDTH    = 40,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned ERR_W    = 16
);
   logic                         start;
   logic [1:0]                   mode;
   logic [CHANNELS*WIDTH-1:0]    in_data;
   logic [CHANNELS*WIDTH-1:0]    out_data;
   logic                         busy;
   logic                         done;
   logic                         passed;
   logic [ERR_W-1:0]             err_count;
   logic [CHANNELS-1:0]          err_chan;

   modport master (
      output start, mode, in_data,
      input  out_data, busy, done, passed, err_count, err_chan
   );

   modport slave (
      input  start, mode, in_data,
      output out_data, busy, done, passed, err_count, err_chan
   );
endinterface

// File: rtl/loopback_selftest.sv
// Multi-channel loopback self-test: drives a mode-selected pattern per channel,
// checks the looped-back data after LOOP_LAT cycles and counts bad beats.
module loopback_selftest #(
   parameter int unsigned WIDTH     = 40,
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned LOOP_LAT  = 1,
   parameter int unsigned RUN_BEATS = 256,
   parameter int unsigned ERR_W     = 16
) (
   input  logic         clk,
   input  logic         reset,
   loopback_selftest_if.slave bus
);

   localparam int unsigned BW     = (RUN_BEATS > 1) ? $clog2(RUN_BEATS) : 1;
   localparam int unsigned DW     = 3;
   localparam int unsigned DATA_W = CHANNELS * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [BW-1:0]       beat_q, beat_d;
   logic [DW-1:0]       drain_q, drain_d;
   logic [DATA_W-1:0]   out_q, out_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic [CHANNELS-1:0] chan_q, chan_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                passed_q, passed_d;
   logic [CHANNELS-1:0] mism_c;
   logic                cmp_valid_c;
   logic [BW-1:0]       cmp_beat_c;

   // Pattern for one channel; index arithmetic wraps at the beat-counter width.
   function automatic logic [WIDTH-1:0] pat(input logic [1:0] md, input logic [BW-1:0] b,
                                            input int c);
      logic [BW-1:0]  s;
      logic [WIDTH-1:0] v;
      int unsigned    idx;
      s   = b + BW'(c);
      idx = 32'(s) % WIDTH;
      case (md)
         2'd0:    v = WIDTH'(s);
         2'd1:    v = WIDTH'(1) << idx;
         2'd2:    v = b[0] ? '1 : '0;
         default: v = ~WIDTH'(s);
      endcase
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] pat_all(input logic [1:0] md, input logic [BW-1:0] b);
      logic [DATA_W-1:0] v;
      v = '0;
      for (int c = 0; c < int'(CHANNELS); c++) v[c*WIDTH +: WIDTH] = pat(md, b, c);
      return v;
   endfunction

   // Delay line carrying (valid, beat) from the pattern output to the compare point.
   if (LOOP_LAT == 0) begin : g_nolat
      assign cmp_valid_c = (state_q == S_RUN);
      assign cmp_beat_c  = beat_q;
   end else begin : g_lat
      logic [LOOP_LAT-1:0] pv_q;
      logic [BW-1:0]       pb_q [LOOP_LAT];
      always_ff @(posedge clk) begin
         if (reset) begin
            pv_q <= '0;
            for (int i = 0; i < int'(LOOP_LAT); i++) pb_q[i] <= '0;
         end else begin
            pv_q[0] <= (state_q == S_RUN);
            pb_q[0] <= beat_q;
            for (int i = 1; i < int'(LOOP_LAT); i++) begin
               pv_q[i] <= pv_q[i-1];
               pb_q[i] <= pb_q[i-1];
            end
         end
      end
      assign cmp_valid_c = pv_q[LOOP_LAT-1];
      assign cmp_beat_c  = pb_q[LOOP_LAT-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         mode_q   <= '0;
         beat_q   <= '0;
         drain_q  <= '0;
         out_q    <= '0;
         err_q    <= '0;
         chan_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         passed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         beat_q   <= beat_d;
         drain_q  <= drain_d;
         out_q    <= out_d;
         err_q    <= err_d;
         chan_q   <= chan_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         passed_q <= passed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      beat_d  = beat_q;
      drain_d = drain_q;
      out_d   = '0;
      err_d   = err_q;
      chan_d  = chan_q;
      mism_c  = '0;

      for (int c = 0; c < int'(CHANNELS); c++)
         mism_c[c] = cmp_valid_c && (bus.in_data[c*WIDTH +: WIDTH] != pat(mode_q, cmp_beat_c, c));
      if (cmp_valid_c) begin
         chan_d = chan_q | mism_c;
         if ((|mism_c) && (err_q != '1)) err_d = err_q + ERR_W'(1);
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_RUN;
               mode_d  = bus.mode;
               beat_d  = '0;
               err_d   = '0;
               chan_d  = '0;
               out_d   = pat_all(bus.mode, '0);
            end
         end
         S_RUN: begin
            if (beat_q == BW'(RUN_BEATS - 1)) begin
               beat_d  = '0;
               drain_d = '0;
               state_d = (LOOP_LAT == 0) ? S_DONE : S_DRAIN;
            end else begin
               beat_d = beat_q + BW'(1);
               out_d  = pat_all(mode_q, beat_q + BW'(1));
            end
         end
         S_DRAIN: begin
            if (drain_q == DW'(LOOP_LAT - 1)) state_d = S_DONE;
            else                              drain_d = drain_q + DW'(1);
         end
         default: state_d = S_IDLE;
      endcase

      busy_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d   = (state_d == S_DONE);
      passed_d = done_d && (err_d == '0);
   end

   assign bus.out_data  = out_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.passed    = passed_q;
   assign bus.err_count = err_q;
   assign bus.err_chan  = chan_q;

endmodule

// File: tb/tb_loopback_selftest.sv
// Randomized bench for loopback_selftest: three configurations checked cycle by
// cycle against a pattern/error model built from the pattern rules.
module tb_loopback_selftest;

   logic         clk;
   logic         rst_g   [3];
   logic         start_g [3];
   logic [1:0]   mode_g  [3];
   logic [127:0] in_g    [3];
   logic [127:0] out_g   [3];
   logic         busy_g  [3];
   logic         done_g  [3];
   logic         pass_g  [3];
   logic [15:0]  err_g   [3];
   logic [7:0]   chan_g  [3];

   int cw  [3] = '{40, 8, 12};
   int cc  [3] = '{2, 1, 3};
   int cl  [3] = '{1, 0, 3};
   int crb [3] = '{256, 10, 40};
   int cew [3] = '{16, 16, 4};

   int n_tests = 0;
   int n_fail  = 0;

   loopback_selftest_if #(.WIDTH(40), .CHANNELS(2), .ERR_W(16)) bus0 ();
   loopback_selftest_if #(.WIDTH(8),  .CHANNELS(1), .ERR_W(16)) bus1 ();
   loopback_selftest_if #(.WIDTH(12), .CHANNELS(3), .ERR_W(4))  bus2 ();

   loopback_selftest #(.WIDTH(40), .CHANNELS(2), .LOOP_LAT(1), .RUN_BEATS(256), .ERR_W(16))
      dut0 (.clk(clk), .reset(rst_g[0]), .bus(bus0.slave));
   loopback_selftest #(.WIDTH(8), .CHANNELS(1), .LOOP_LAT(0), .RUN_BEATS(10), .ERR_W(16))
      dut1 (.clk(clk), .reset(rst_g[1]), .bus(bus1.slave));
   loopback_selftest #(.WIDTH(12), .CHANNELS(3), .LOOP_LAT(3), .RUN_BEATS(40), .ERR_W(4))
      dut2 (.clk(clk), .reset(rst_g[2]), .bus(bus2.slave));

   assign bus0.start = start_g[0];  assign bus0.mode = mode_g[0];  assign bus0.in_data = in_g[0][79:0];
   assign bus1.start = start_g[1];  assign bus1.mode = mode_g[1];  assign bus1.in_data = in_g[1][7:0];
   assign bus2.start = start_g[2];  assign bus2.mode = mode_g[2];  assign bus2.in_data = in_g[2][35:0];

   assign out_g[0] = 128'(bus0.out_data); assign busy_g[0] = bus0.busy; assign done_g[0] = bus0.done;
   assign pass_g[0] = bus0.passed; assign err_g[0] = bus0.err_count; assign chan_g[0] = 8'(bus0.err_chan);
   assign out_g[1] = 128'(bus1.out_data); assign busy_g[1] = bus1.busy; assign done_g[1] = bus1.done;
   assign pass_g[1] = bus1.passed; assign err_g[1] = bus1.err_count; assign chan_g[1] = 8'(bus1.err_chan);
   assign out_g[2] = 128'(bus2.out_data); assign busy_g[2] = bus2.busy; assign done_g[2] = bus2.done;
   assign pass_g[2] = bus2.passed; assign err_g[2] = 16'(bus2.err_count); assign chan_g[2] = 8'(bus2.err_chan);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] wmask(input int w);
      return (w >= 128) ? '1 : ((128'(1) << w) - 128'(1));
   endfunction

   // Pattern value of channel c at beat b, from the mode definitions.
   function automatic logic [127:0] ref_pat(input int id, input int b, input int c, input int md);
      int bw = 1;
      int s;
      int w = cw[id];
      while ((1 << bw) < crb[id]) bw++;
      s = (b + c) % (1 << bw);
      case (md)
         0:       return 128'(s) & wmask(w);
         1:       return 128'(1) << (s % w);
         2:       return (b % 2 == 1) ? wmask(w) : 128'(0);
         default: return ~128'(s) & wmask(w);
      endcase
   endfunction

   function automatic logic [127:0] ref_all(input int id, input int b, input int md);
      logic [127:0] v = '0;
      for (int c = 0; c < cc[id]; c++) v |= ref_pat(id, b, c, md) << (c * cw[id]);
      return v;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_all(input int id, input string tag, input logic [127:0] eo, input logic eb,
                            input logic ed, input logic ep, input int ee, input logic [7:0] ech);
      check($sformatf("%0d:%s:out", id, tag),    out_g[id],  eo);
      check($sformatf("%0d:%s:busy", id, tag),   128'(busy_g[id]), 128'(eb));
      check($sformatf("%0d:%s:done", id, tag),   128'(done_g[id]), 128'(ed));
      check($sformatf("%0d:%s:passed", id, tag), 128'(pass_g[id]), 128'(ep));
      check($sformatf("%0d:%s:err", id, tag),    128'(err_g[id]),  128'(ee));
      check($sformatf("%0d:%s:chan", id, tag),   128'(chan_g[id]), 128'(ech));
   endtask

   // fault: 0 clean, 1 random corruption, 2 ch1 bit5 stuck 0, 3 every beat inverted.
   task automatic run(input int id, input int md, input int fault, input int reset_at,
                      input int extra_start_at);
      int           w = cw[id], ch = cc[id], l = cl[id], rb = crb[id];
      int           sat = (1 << cew[id]) - 1;
      int           exp_err = 0;
      logic [7:0]   exp_chan = '0;
      logic [127:0] dm = wmask(ch * w);
      logic [127:0] p, drv;
      int           b;
      logic         any;
      @(negedge clk);
      start_g[id] = 1'b1;
      mode_g[id]  = 2'(md);
      in_g[id]    = rnd128() & dm;
      for (int k = 1; k <= rb + l + 1; k++) begin
         @(negedge clk);
         if (reset_at > 0 && k == reset_at + 1) begin
            check_all(id, $sformatf("rst@%0d", k), '0, 1'b0, 1'b0, 1'b0, 0, '0);
            rst_g[id] = 1'b0;
            return;
         end
         check_all(id, $sformatf("m%0d@%0d", md, k), (k <= rb) ? ref_all(id, k - 1, md) : '0,
                   k <= rb + l, k == rb + l + 1, (k == rb + l + 1) && exp_err == 0,
                   exp_err, exp_chan);
         if (k == reset_at) rst_g[id] = 1'b1;
         start_g[id] = (k == extra_start_at);
         mode_g[id]  = 2'($urandom);
         b = k - 1 - l;
         if (b >= 0 && b < rb) begin
            p = ref_all(id, b, md);
            case (fault)
               1:       drv = ($urandom_range(0, 3) == 0) ? p ^ (rnd128() & dm) : p;
               2:       drv = p & ~(128'(1) << (w + 5));
               3:       drv = ~p & dm;
               default: drv = p;
            endcase
            any = 1'b0;
            for (int c = 0; c < ch; c++)
               if (((drv >> (c * w)) & wmask(w)) != ((p >> (c * w)) & wmask(w))) begin
                  exp_chan[c] = 1'b1;
                  any = 1'b1;
               end
            if (any && exp_err < sat) exp_err++;
         end else begin
            drv = rnd128() & dm;
         end
         in_g[id] = drv;
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_g[i] = 1'b1; start_g[i] = 1'b0; mode_g[i] = '0; in_g[i] = '0;
      end
      start_g[0] = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) check_all(i, "reset", '0, 1'b0, 1'b0, 1'b0, 0, '0);
      start_g[0] = 1'b0;
      for (int i = 0; i < 3; i++) rst_g[i] = 1'b0;

      run(0, 0, 0, 0, 0);
      check("tp1_passed", 128'(pass_g[0]), 128'(1));
      run(1, 1, 0, 0, 0);
      check("tp2_passed", 128'(pass_g[1]), 128'(1));
      run(0, 2, 2, 0, 0);
      check("tp3_err", 128'(err_g[0]), 128'(128));
      check("tp3_chan", 128'(chan_g[0]), 128'(2));
      check("tp3_passed", 128'(pass_g[0]), 128'(0));
      run(2, 3, 3, 0, 0);
      check("tp4_err_sat", 128'(err_g[2]), 128'(15));
      check("tp4_chan", 128'(chan_g[2]), 128'(7));

      run(0, 1, 0, 100, 0);
      repeat (2) begin
         @(negedge clk);
         check_all(0, "post_rst", '0, 1'b0, 1'b0, 1'b0, 0, '0);
      end
      run(0, 0, 0, 0, 0);
      check("tp5_passed", 128'(pass_g[0]), 128'(1));

      run(0, int'($urandom_range(0, 3)), 1, 0, 50);
      run(0, 2, 0, 0, 0);
      check("tp6_passed", 128'(pass_g[0]), 128'(1));

      for (int i = 0; i < 8; i++)
         run(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
